psx_pad_responder: RTL and testbench
====================================

# psx_pad_responder

Controller-side endpoint of the PSX pad link: emulates a digital pad answering the console's poll. It oversamples the console's `psx_clk`, `cmd` and `att` on the local system clock. It shifts out the pad ID and button state on `data` and pulses `ack` after each acknowledged byte. It sits opposite `fake_psx` on the same four-wire link and lets the host-side block be tested without a real controller.

## Interface
- `ACK_DELAY`, default 8: `clk` cycles from the byte's 8th sampling edge to `ack` falling.
- `ACK_WIDTH`, default 4: `clk` cycles `ack` is held low.
- `clk`  input  1  system clock; frequency must be at least 8× the `psx_clk` frequency.
- `rst_n`  input  1  asynchronous, active-low reset.
- `psx_clk`  input  1  link clock from console; idles high; asynchronous to `clk`.
- `cmd`  input  1  console command bit, LSB first; sampled on `psx_clk` rising edge.
- `att`  input  1  active-low select from console; low for the whole transaction.
- `buttons`  input  16  pressed = 1; bit 0 is SELECT … bit 15 is SQUARE, in standard pad order.
- `data`  output  1  response bit to console, LSB first; idle/released = 1.
- `ack`  output  1  active-low acknowledge pulse; idle = 1.
- `poll_done`  output  1  one-`clk` pulse when a full 5-byte poll completes.

## Operation
- `psx_clk`, `cmd` and `att` each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
- Transaction packet:

  | Byte | Console sends | Pad returns |
  |------|---------------|-------------|
  | 0 | 0x01 | 0xFF |
  | 1 | 0x42 | 0x41 |
  | 2 | (any) | 0x5A |
  | 3 | (any) | ~btn_lat[7:0] |
  | 4 | (any) | ~btn_lat[15:8] |

- `btn_lat` is the value of `buttons` captured on the `clk` cycle the synchronized `att` falls. It is stable for the rest of the transaction.
- Within each byte:
  - Bit i of the response is driven on the i-th synchronized `psx_clk` falling edge.
  - `cmd` bit i is sampled on the i-th rising edge into an 8-bit shift register.
  - A 3-bit counter counts rising edges; the 8th rising edge completes the byte.
- States:
  - **IDLE**
    - `data` = 1, `ack` = 1.
    - Synchronized `att` falling: latch `buttons`, set byte index to 0, load the response byte, go to SHIFT.
  - **SHIFT**
    - Shift per the rules above.
    - Byte complete, any of the following: go to IGNORE (no ack).
      - Byte 0 with received ≠ 0x01.
      - Byte 1 with received ≠ 0x42.
    - Byte complete, index 4: pulse `poll_done` and go to DONE.
    - Otherwise: go to ACK_WAIT.
  - **ACK_WAIT**
    - Count `ACK_DELAY` cycles, then go to ACK_PULSE.
  - **ACK_PULSE**
    - `ack` = 0 for `ACK_WIDTH` cycles.
    - Then increment the byte index, load the next response byte, and go to SHIFT.
  - **DONE / IGNORE**
    - `data` = 1, `ack` = 1.
    - Wait for synchronized `att` high, then go to IDLE.
- Abort rules:
  - Synchronized `att` high in any state: go to IDLE immediately and release `data`/`ack` to 1.
  - This takes priority over any simultaneous `psx_clk` edge.
  - An aborted transaction never pulses `poll_done`.
- Abort rules for `psx_clk` edges:
  - A `psx_clk` edge during ACK_WAIT or ACK_PULSE aborts to IGNORE.
  - The console must not clock before `ack`.
- `data` keeps its last driven bit between the 8th rising edge and the next byte's first falling edge.

## Timing
- Reset values: `data` = 1, `ack` = 1, `poll_done` = 0. State is IDLE and all counters are 0.
- Reset is asynchronous: outputs reach their reset values without a `clk` edge, including mid-transaction.
- Input-to-action latency is 3 `clk` cycles (2 sync + 1 edge detect/register):
  - `psx_clk` falling edge → new `data` bit.
  - `att` falling edge → latch of `buttons`.
  - `att` rising edge → release of `data`/`ack`.
- Ack timing:
  - `ack` falls exactly `ACK_DELAY` `clk` cycles after the cycle the 8th rising edge is detected.
  - `ack` stays low exactly `ACK_WIDTH` cycles.
- `poll_done` asserts on the cycle the 8th rising edge of byte 4 is detected.
- Minimum `psx_clk` half-period is 4 `clk` cycles. Behaviour below this is undefined.

## Test plan
1. **Nominal poll.** `buttons` = 16'h0001; console sends 01,42,00,00,00.
   - `data` returns FF,41,5A,FE,FF.
   - Exactly 4 `ack` pulses, each `ACK_WIDTH` long and `ACK_DELAY` after its byte.
   - One `poll_done`.
2. **Wrong device address.** First byte 0x81.
   - `data` reads FF.
   - No `ack`.
   - `data` stays 1 until `att` rises.
   - A following valid poll works normally.
3. **Wrong command byte.** Byte 1 = 0x43.
   - Byte 1 returns 0x41.
   - No `ack` after byte 1.
   - Remaining clocks see `data` = 1.
   - No `poll_done`.
4. **Abort during byte 3.** `att` rises after 3 bits of byte 3.
   - `data` = 1 and `ack` = 1 within 3 `clk` cycles.
   - No `poll_done`.
   - The next poll returns the full correct packet.
5. **Buttons change mid-transaction.** `buttons` changes 16'h0000→16'hFFFF during byte 2.
   - Bytes 3 and 4 return FF,FF (pre-change value).
   - The next poll returns 00,00.
6. **Reset mid-transaction.** `rst_n` goes low mid-byte 1 while `data` = 0.
   - `data`/`ack` go to 1 immediately without a `clk` edge.
   - After release, the block is in IDLE and answers a fresh poll correctly.

Source files
------------

// File: rtl/psx_pad_responder.sv
// Digital-pad emulator on the PSX pad link: oversamples psx_clk/cmd/att on clk,
// shifts out ID and button bytes on data and pulses ack after each accepted byte.
module psx_pad_responder #(
  parameter int ACK_DELAY = 8,
  parameter int ACK_WIDTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_psx_clk,
  input  logic        i_cmd,
  input  logic        i_att,
  input  logic [15:0] i_buttons,
  output logic        o_data,
  output logic        o_ack,
  output logic        o_poll_done
);

  localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CW-1:0] DLY_LAST = CW'(ACK_DELAY - 1);
  localparam logic [CW-1:0] WID_LAST = CW'(ACK_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_ACK_WAIT  = 3'd2,
    ST_ACK_PULSE = 3'd3,
    ST_DONE      = 3'd4,
    ST_IGNORE    = 3'd5
  } state_t;

  // Response byte for a given packet index; button bytes are active-low on the wire.
  function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [15:0] btn);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'hFF;
      3'd1:    b = 8'h41;
      3'd2:    b = 8'h5A;
      3'd3:    b = ~btn[7:0];
      3'd4:    b = ~btn[15:8];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  logic          r_clk_s1, r_clk_s2, r_clk_d;
  logic          r_cmd_s1, r_cmd_s2;
  logic          r_att_s1, r_att_s2, r_att_d;
  state_t        r_state, w_state_nxt;
  logic [15:0]   r_btn, w_btn_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_tx, w_tx_nxt;
  logic [6:0]    r_rx, w_rx_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_data, w_data_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_poll, w_poll_nxt;

  logic          w_psx_rise, w_psx_fall, w_att_fall;
  logic [7:0]    w_rx_byte;
  logic [2:0]    w_idx_inc;

  assign w_psx_rise = r_clk_s2 & ~r_clk_d;
  assign w_psx_fall = ~r_clk_s2 & r_clk_d;
  assign w_att_fall = ~r_att_s2 & r_att_d;
  assign w_rx_byte  = {r_cmd_s2, r_rx};
  assign w_idx_inc  = r_idx + 3'd1;

  // Two-flop synchronizers plus one delay stage for edge detection; idle-high reset values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_cmd_s1 <= 1'b1;
      r_cmd_s2 <= 1'b1;
      r_att_s1 <= 1'b1;
      r_att_s2 <= 1'b1;
      r_att_d  <= 1'b1;
    end else begin
      r_clk_s1 <= i_psx_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_cmd_s1 <= i_cmd;
      r_cmd_s2 <= r_cmd_s1;
      r_att_s1 <= i_att;
      r_att_s2 <= r_att_s1;
      r_att_d  <= r_att_s2;
    end
  end

  // Next-state and datapath; an att release beats any psx_clk edge in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_btn_nxt   = r_btn;
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_bit_nxt   = r_bit;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_ack_nxt   = 1'b1;
    w_poll_nxt  = 1'b0;
    if (r_att_s2 && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_data_nxt  = 1'b1;
      w_cnt_nxt   = '0;
      w_bit_nxt   = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_data_nxt = 1'b1;
          if (w_att_fall) begin
            w_btn_nxt   = i_buttons;
            w_idx_nxt   = 3'd0;
            w_tx_nxt    = resp_byte(3'd0, i_buttons);
            w_bit_nxt   = 3'd0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_psx_fall) begin
            w_data_nxt = r_tx[0];
            w_tx_nxt   = {1'b1, r_tx[7:1]};
          end else begin
            w_data_nxt = r_data;
          end
          if (w_psx_rise) begin
            w_rx_nxt  = {r_cmd_s2, r_rx[6:1]};
            w_bit_nxt = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              w_cnt_nxt = '0;
              if (((r_idx == 3'd0) && (w_rx_byte != 8'h01)) ||
                  ((r_idx == 3'd1) && (w_rx_byte != 8'h42))) begin
                w_state_nxt = ST_IGNORE;
                w_data_nxt  = 1'b1;
              end else if (r_idx == 3'd4) begin
                w_poll_nxt  = 1'b1;
                w_state_nxt = ST_DONE;
                w_data_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_ACK_WAIT;
              end
            end else begin
              w_state_nxt = ST_SHIFT;
            end
          end else begin
            w_rx_nxt = r_rx;
          end
        end
        ST_ACK_WAIT: begin
          if (w_psx_rise || w_psx_fall) begin
            w_state_nxt = ST_IGNORE;
            w_data_nxt  = 1'b1;
          end else if (r_cnt == DLY_LAST) begin
            w_state_nxt = ST_ACK_PULSE;
            w_cnt_nxt   = '0;
            w_ack_nxt   = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_ACK_PULSE: begin
          if (w_psx_rise || w_psx_fall) begin
            w_state_nxt = ST_IGNORE;
            w_data_nxt  = 1'b1;
          end else if (r_cnt == WID_LAST) begin
            w_idx_nxt   = w_idx_inc;
            w_tx_nxt    = resp_byte(w_idx_inc, r_btn);
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            w_ack_nxt = 1'b0;
          end
        end
        ST_DONE, ST_IGNORE: begin
          w_data_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_data_nxt  = 1'b1;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_btn   <= 16'h0000;
      r_idx   <= 3'd0;
      r_tx    <= 8'hFF;
      r_rx    <= 7'd0;
      r_bit   <= 3'd0;
      r_cnt   <= '0;
      r_data  <= 1'b1;
      r_ack   <= 1'b1;
      r_poll  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_btn   <= w_btn_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_bit   <= w_bit_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_ack   <= w_ack_nxt;
      r_poll  <= w_poll_nxt;
    end
  end

  assign o_data      = r_data;
  assign o_ack       = r_ack;
  assign o_poll_done = r_poll;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Directed bench for psx_pad_responder: plays the console side of the pad link.
module tb_psx_pad_responder;
  localparam int AD = 8;
  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic        att = 1'b1;
  logic [15:0] buttons = 16'h0000;
  logic        data, ack, poll_done;

  int n_tests = 0;
  int n_fail = 0;
  int n_ack_falls = 0;
  int n_polls = 0;
  logic ack_q = 1'b1;

  always #5 clk = ~clk;

  psx_pad_responder #(.ACK_DELAY(AD), .ACK_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_psx_clk(psx_clk), .i_cmd(cmd), .i_att(att),
    .i_buttons(buttons), .o_data(data), .o_ack(ack), .o_poll_done(poll_done)
  );

  // Running tallies of ack pulses and poll_done cycles.
  always @(negedge clk) begin
    if (ack_q && !ack) n_ack_falls <= n_ack_falls + 1;
    ack_q <= ack;
    if (poll_done) n_polls <= n_polls + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One byte from the console: 4-cycle half periods, then a bounded window watching ack/poll_done.
  task automatic xfer(input logic [7:0] c, input int nbits, output logic [7:0] rx,
                      output int ack_at, output int ack_len, output int pd_at);
    rx = 8'h00; ack_at = -1; ack_len = 0; pd_at = -1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      psx_clk = 1'b0;
      cmd = c[i];
      repeat (4) @(negedge clk);
      rx[i] = data;
      psx_clk = 1'b1;
      if (i < 7) repeat (3) @(negedge clk);
    end
    if (nbits == 8) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (!ack) begin
          if (ack_at < 0) ack_at = k;
          ack_len++;
        end
        if (poll_done && pd_at < 0) pd_at = k;
      end
    end
  endtask

  task automatic byte_chk(input string tag, input logic [7:0] c, input logic [7:0] exp,
                          input bit exp_ack, input bit exp_pd);
    logic [7:0] rx;
    int aa, al, pd;
    xfer(c, 8, rx, aa, al, pd);
    check_val({tag, ".rx"}, rx, exp);
    check_val({tag, ".ack_at"}, aa, exp_ack ? 3 + AD : -1);
    check_val({tag, ".ack_len"}, al, exp_ack ? AW : 0);
    check_val({tag, ".pd_at"}, pd, exp_pd ? 3 : -1);
  endtask

  task automatic begin_poll();
    @(negedge clk);
    att = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic end_poll();
    @(negedge clk);
    att = 1'b1;
    psx_clk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic full_poll(input string tag, input logic [15:0] btn);
    logic [15:0] nb;
    nb = ~btn;
    buttons = btn;
    begin_poll();
    byte_chk({tag, ".b0"}, 8'h01, 8'hFF, 1'b1, 1'b0);
    byte_chk({tag, ".b1"}, 8'h42, 8'h41, 1'b1, 1'b0);
    byte_chk({tag, ".b2"}, 8'h00, 8'h5A, 1'b1, 1'b0);
    byte_chk({tag, ".b3"}, 8'h00, nb[7:0], 1'b1, 1'b0);
    byte_chk({tag, ".b4"}, 8'h00, nb[15:8], 1'b0, 1'b1);
    end_poll();
  endtask

  initial begin
    logic [7:0] rx;
    int aa, al, pd, acks0, polls0;

    #1 rst_n = 1'b0;
    #2;
    check_val("reset.data", data, 1'b1);
    check_val("reset.ack", ack, 1'b1);
    check_val("reset.poll_done", poll_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Nominal poll
    acks0 = n_ack_falls; polls0 = n_polls;
    full_poll("nominal", 16'h0001);
    check_val("nominal.ack_count", n_ack_falls - acks0, 4);
    check_val("nominal.poll_count", n_polls - polls0, 1);

    // Wrong device address
    acks0 = n_ack_falls;
    begin_poll();
    byte_chk("badaddr.b0", 8'h81, 8'hFF, 1'b0, 1'b0);
    byte_chk("badaddr.b1", 8'h42, 8'hFF, 1'b0, 1'b0);
    check_val("badaddr.data_idle", data, 1'b1);
    end_poll();
    check_val("badaddr.ack_count", n_ack_falls - acks0, 0);
    full_poll("after_badaddr", 16'h1234);

    // Wrong command byte
    polls0 = n_polls;
    buttons = 16'h0000;
    begin_poll();
    byte_chk("badcmd.b0", 8'h01, 8'hFF, 1'b1, 1'b0);
    byte_chk("badcmd.b1", 8'h43, 8'h41, 1'b0, 1'b0);
    byte_chk("badcmd.b2", 8'h00, 8'hFF, 1'b0, 1'b0);
    byte_chk("badcmd.b3", 8'h00, 8'hFF, 1'b0, 1'b0);
    byte_chk("badcmd.b4", 8'h00, 8'hFF, 1'b0, 1'b0);
    end_poll();
    check_val("badcmd.poll_count", n_polls - polls0, 0);

    // Abort after 3 bits of byte 3 (response 0xF9 leaves data low)
    polls0 = n_polls;
    buttons = 16'h0006;
    begin_poll();
    byte_chk("abort.b0", 8'h01, 8'hFF, 1'b1, 1'b0);
    byte_chk("abort.b1", 8'h42, 8'h41, 1'b1, 1'b0);
    byte_chk("abort.b2", 8'h00, 8'h5A, 1'b1, 1'b0);
    xfer(8'h00, 3, rx, aa, al, pd);
    check_val("abort.b3_partial", rx[2:0], 3'b001);
    @(negedge clk);
    att = 1'b1;
    repeat (2) @(negedge clk);
    check_val("abort.data_held", data, 1'b0);
    @(negedge clk);
    check_val("abort.data_rel", data, 1'b1);
    check_val("abort.ack_rel", ack, 1'b1);
    repeat (30) @(negedge clk);
    check_val("abort.poll_count", n_polls - polls0, 0);
    full_poll("after_abort", 16'h0006);

    // Buttons change after latch
    buttons = 16'h0000;
    begin_poll();
    byte_chk("btnchg.b0", 8'h01, 8'hFF, 1'b1, 1'b0);
    byte_chk("btnchg.b1", 8'h42, 8'h41, 1'b1, 1'b0);
    buttons = 16'hFFFF;
    byte_chk("btnchg.b2", 8'h00, 8'h5A, 1'b1, 1'b0);
    byte_chk("btnchg.b3", 8'h00, 8'hFF, 1'b1, 1'b0);
    byte_chk("btnchg.b4", 8'h00, 8'hFF, 1'b0, 1'b1);
    end_poll();
    full_poll("after_btnchg", 16'hFFFF);

    // Reset mid byte 1 while data is low
    buttons = 16'h00A5;
    begin_poll();
    byte_chk("rst.b0", 8'h01, 8'hFF, 1'b1, 1'b0);
    xfer(8'h42, 2, rx, aa, al, pd);
    check_val("rst.data_low", data, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst.data_async", data, 1'b1);
    check_val("rst.ack_async", ack, 1'b1);
    att = 1'b1;
    psx_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    full_poll("after_rst", 16'h00A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
